inst_fetch: RTL and testbench
=============================

// Module: inst_fetch
// PURPOSE
//  Instruction-fetch stage with a direct-mapped I-cache. It sits upstream of the memory
//  controller and downstream of the PC/branch logic. Hits are served in 1 cycle. A miss
//  asserts if_request toward the memory controller and waits for the 4-byte fill.
//  The fetched pc/inst pair goes to the IF/ID latch. A redirect from the EX stage
//  (jump_or_not) flushes the stage.
// PARAMETERS
//  ADDR_W   32   byte-address width (matches `AddrLen)
//  INST_W   32   instruction width (matches `InstLen)
//  INDEX_W  7    cache index bits; 2**INDEX_W lines, one 32-bit instruction per line
// PORTS
//  clk            in   1        clock, rising edge
//  rst            in   1        reset: synchronous, active-high
//  rdy            in   1        global ready; low = every register holds its value
//  stall_in       in   1        downstream not accepting; hold the delivered pair
//  jump_or_not    in   1        redirect request (same signal the memory controller sees)
//  jump_addr      in   ADDR_W   redirect target
//  mem_if_addr    out  ADDR_W   fetch address to the memory controller (if_addr)
//  mem_if_request out  1        fetch request to the memory controller (if_request)
//  mem_if_inst    in   INST_W   fill data from the memory controller (if_inst)
//  mem_if_enable  in   1        1-cycle pulse: mem_if_inst is valid
//  id_pc          out  ADDR_W   pc of the delivered instruction
//  id_inst        out  INST_W   delivered instruction
//  id_valid       out  1        id_pc/id_inst are valid this cycle
// BEHAVIOUR
//  Reset: pc=0, state=S_LOOKUP, all line valid bits=0, id_pc=0, id_inst=0, id_valid=0.
//   mem_if_request=0; mem_if_addr=0 (driven from pc).
//  Address split: index=pc[INDEX_W+1:2]; tag=pc[ADDR_W-1:INDEX_W+2]; pc[1:0] ignored.
//  S_LOOKUP: combinational tag compare.
//   - Hit and !stall_in: register id_pc=pc, id_inst=line data, id_valid=1; pc+=4.
//   - Hit and stall_in: hold id_* and pc.
//   - Miss: go to S_MISS. No delivery. id_valid=0 unless stall_in holds an older pair.
//  S_MISS: mem_if_request=1 and mem_if_addr=pc, both held stable until mem_if_enable.
//   - On mem_if_enable: write {valid=1, tag, data} into line[index]; go to S_LOOKUP.
//   - If !stall_in at that point, also deliver (id_pc=pc, id_inst=mem_if_inst,
//     id_valid=1, pc+=4). If stall_in, deliver nothing; the refetch then hits.
//  Latency: hit = 1 cycle pc->id_valid. Miss = controller fill time + 1.
//  id_valid is a per-cycle flag. It stays high while stall_in holds a pair and drops
//   after one cycle once consumed if no new fetch is ready.
//  Redirect (jump_or_not=1), any state, highest priority:
//   pc<=jump_addr; id_valid<=0; state<=S_LOOKUP; mem_if_request=0 in that same cycle
//   (combinational). The memory controller abandons the fetch on the same signal.
//   mem_if_enable in a redirect cycle is ignored: no cache write.
//  Simultaneous redirect+stall: redirect wins, and the held pair is dropped.
//  Simultaneous fill+redirect: redirect wins.
//  rdy=0: pc, state, valid bits, cache and id_* all frozen. Combinational outputs
//   follow the frozen state.
//  Reset mid-miss: request drops the next cycle and all lines are invalidated.
//   The memory controller is reset by the same rst.
//  pc wraps modulo 2**ADDR_W (0xFFFFFFFC+4 -> 0).
//  Cache data is never written by stores (no self-modifying-code support).
// STRUCTURE
//  config.v: add `S_LOOKUP/`S_MISS state codes and `ICacheIndexW.
//   Reuse `AddrLen, `InstLen, `ZERO_WORD, `True/`False.
//  Sub-module icache_dm: valid vector (reset), tag+data arrays (not reset),
//   with read port (index -> hit, data) and write port (we, index, tag, data).
//  inst_fetch holds pc, the 2-state FSM and the id_* registers.
// TESTING
//  1 Cold start: mem returns 0x00000013 at addr 0 -> request@0, id_valid with
//    id_pc=0 / id_inst=0x13 one cycle after enable; next request addr=4.
//  2 Loop 0..0xC with a jump back to 0: second pass has no mem_if_request, and one
//    instruction is delivered per cycle.
//  3 Redirect mid-miss at addr 8 to 0x100: request drops the same cycle, enable is
//    ignored, next request addr=0x100, line for 8 stays invalid.
//  4 stall_in=1 for 3 cycles after a hit delivery -> id_pc/id_inst/id_valid held and
//    pc unchanged. Release -> next pc+4.
//  5 Conflict: fetch 0x000 then 0x200 (same index, INDEX_W=7) -> both miss, and
//    refetching 0x000 misses again.
//  6 rdy=0 for 4 cycles during S_MISS and during a hit -> no state/output change.
//    rst pulse mid-miss -> pc=0, all lines invalid.

Source files
------------

// File: rtl/inst_fetch_pkg.sv
// Shared types and default widths for the instruction-fetch stage and its I-cache.
package inst_fetch_pkg;

  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_INST_W  = 32;
  localparam int DEF_INDEX_W = 7;

  // Fetch FSM: either looking the pc up in the cache or waiting on a fill
  typedef enum logic {
    S_LOOKUP = 1'b0,
    S_MISS   = 1'b1
  } fetch_state_t;

  // Tag width left over once the word offset and the index are removed
  function automatic int tag_width(input int addr_w, input int index_w);
    return addr_w - index_w - 2;
  endfunction

endpackage

// File: rtl/inst_fetch_icache.sv
// Direct-mapped instruction cache, one instruction per line.
// Only the valid bits are reset; tags and data are qualified by valid.
module icache_dm
  import inst_fetch_pkg::*;
#(
  parameter int INDEX_W = DEF_INDEX_W,
  parameter int TAG_W   = tag_width(DEF_ADDR_W, DEF_INDEX_W),
  parameter int DATA_W  = DEF_INST_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rdy,
  input  logic [INDEX_W-1:0] rd_index,
  input  logic [TAG_W-1:0]   rd_tag,
  output logic               hit,
  output logic [DATA_W-1:0]  rd_data,
  input  logic               we,
  input  logic [INDEX_W-1:0] wr_index,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic [DATA_W-1:0]  wr_data
);

  localparam int LINES = 1 << INDEX_W;

  logic [LINES-1:0]  valid;
  logic [TAG_W-1:0]  tags [LINES];
  logic [DATA_W-1:0] data [LINES];

  // Valid bits: cleared on reset, set by a fill, frozen while rdy is low
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
    end else if (rdy && we) begin
      valid[wr_index] <= 1'b1;
    end
  end

  // Tag and data storage: written only by fills, no reset needed
  always_ff @(posedge clk) begin
    if (rdy && we) begin
      tags[wr_index] <= wr_tag;
      data[wr_index] <= wr_data;
    end
  end

  assign hit     = valid[rd_index] && (tags[rd_index] == rd_tag);
  assign rd_data = data[rd_index];

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: pc register, lookup/miss FSM and the IF/ID output
// registers, backed by a direct-mapped I-cache filled from the memory controller.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int INST_W  = DEF_INST_W,
  parameter int INDEX_W = DEF_INDEX_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              stall_in,
  input  logic              jump_or_not,
  input  logic [ADDR_W-1:0] jump_addr,
  output logic [ADDR_W-1:0] mem_if_addr,
  output logic              mem_if_request,
  input  logic [INST_W-1:0] mem_if_inst,
  input  logic              mem_if_enable,
  output logic [ADDR_W-1:0] id_pc,
  output logic [INST_W-1:0] id_inst,
  output logic              id_valid
);

  localparam int TAG_W = tag_width(ADDR_W, INDEX_W);

  logic [ADDR_W-1:0]  pc;
  fetch_state_t       state;
  logic [INDEX_W-1:0] index;
  logic [TAG_W-1:0]   tag;
  logic               hit;
  logic [INST_W-1:0]  line_data;
  logic               fill_we;

  assign index = pc[INDEX_W+1:2];
  assign tag   = pc[ADDR_W-1:INDEX_W+2];

  // A redirect kills the outstanding request in the very cycle it is raised
  assign mem_if_request = (state == S_MISS) && !jump_or_not;
  assign mem_if_addr    = pc;

  // Fills arriving together with a redirect belong to the abandoned fetch
  assign fill_we = (state == S_MISS) && mem_if_enable && !jump_or_not && !rst;

  icache_dm #(
    .INDEX_W (INDEX_W),
    .TAG_W   (TAG_W),
    .DATA_W  (INST_W)
  ) u_icache (
    .clk      (clk),
    .rst      (rst),
    .rdy      (rdy),
    .rd_index (index),
    .rd_tag   (tag),
    .hit      (hit),
    .rd_data  (line_data),
    .we       (fill_we),
    .wr_index (index),
    .wr_tag   (tag),
    .wr_data  (mem_if_inst)
  );

  // Fetch FSM with pc and IF/ID registers; redirect beats stall, fill and lookup
  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= '0;
      state    <= S_LOOKUP;
      id_pc    <= '0;
      id_inst  <= '0;
      id_valid <= 1'b0;
    end else if (rdy) begin
      if (jump_or_not) begin
        pc       <= jump_addr;
        id_valid <= 1'b0;
        state    <= S_LOOKUP;
      end else begin
        case (state)
          S_LOOKUP: begin
            if (hit) begin
              if (!stall_in) begin
                id_pc    <= pc;
                id_inst  <= line_data;
                id_valid <= 1'b1;
                pc       <= pc + ADDR_W'(4);
              end
            end else begin
              state <= S_MISS;
              if (!stall_in) begin
                id_valid <= 1'b0;
              end
            end
          end
          S_MISS: begin
            if (mem_if_enable) begin
              state <= S_LOOKUP;
              if (!stall_in) begin
                id_pc    <= pc;
                id_inst  <= mem_if_inst;
                id_valid <= 1'b1;
                pc       <= pc + ADDR_W'(4);
              end
            end else if (!stall_in) begin
              id_valid <= 1'b0;
            end
          end
          default: state <= S_LOOKUP;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Testbench for inst_fetch: directed scenarios followed by a randomized phase,
// all checked against a cycle-level reference model of the fetch stage.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        stall_in;
  logic        jump_or_not;
  logic [31:0] jump_addr;
  logic [31:0] mem_if_addr;
  logic        mem_if_request;
  logic [31:0] mem_if_inst;
  logic        mem_if_enable;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_valid;

  int total  = 0;
  int passed = 0;

  // Reference model: cache as (valid, word address) per index, plus a pending-fill flag
  bit          m_valid [128];
  logic [29:0] m_line  [128];
  logic [31:0] m_pc;
  bit          m_pending;
  logic [31:0] e_id_pc;
  logic [31:0] e_id_inst;
  bit          e_id_valid;
  int          m_wait;
  int          m_lat;

  inst_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .rdy            (rdy),
    .stall_in       (stall_in),
    .jump_or_not    (jump_or_not),
    .jump_addr      (jump_addr),
    .mem_if_addr    (mem_if_addr),
    .mem_if_request (mem_if_request),
    .mem_if_inst    (mem_if_inst),
    .mem_if_enable  (mem_if_enable),
    .id_pc          (id_pc),
    .id_inst        (id_inst),
    .id_valid       (id_valid)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Memory contents seen by the fetch stage; address 0 holds 0x00000013
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a * 32'h9E3779B1 + 32'h00000013;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // One clock cycle: drive inputs, check combinational outputs, advance model, check registers
  task automatic applyStimulus(input bit rst_v, input bit rdy_v, input bit stall_v,
                               input bit jmp_v, input logic [31:0] jaddr_v, input bit en_v);
    logic [31:0] fill;
    int          idx;
    bit          hit;
    @(negedge clk);
    fill          = en_v ? mem_word(m_pc) : 32'($urandom);
    rst           = rst_v;
    rdy           = rdy_v;
    stall_in      = stall_v;
    jump_or_not   = jmp_v;
    jump_addr     = jaddr_v;
    mem_if_enable = en_v;
    mem_if_inst   = fill;
    #1;
    checkOutput("comb_req", 32'(mem_if_request), 32'(m_pending && !jmp_v));
    checkOutput("comb_addr", mem_if_addr, m_pc);
    idx = int'(m_pc[8:2]);
    hit = m_valid[idx] && (m_line[idx] == m_pc[31:2]);
    if (rst_v) begin
      m_pc = 0; m_pending = 0; e_id_pc = 0; e_id_inst = 0; e_id_valid = 0;
      for (int i = 0; i < 128; i++) m_valid[i] = 0;
    end else if (rdy_v) begin
      if (jmp_v) begin
        m_pc = jaddr_v; e_id_valid = 0; m_pending = 0;
      end else if (!m_pending) begin
        if (hit) begin
          if (!stall_v) begin
            e_id_pc = m_pc; e_id_inst = mem_word(m_pc); e_id_valid = 1; m_pc = m_pc + 4;
          end
        end else begin
          m_pending = 1; m_wait = 0; m_lat = int'($urandom_range(0, 2));
          if (!stall_v) e_id_valid = 0;
        end
      end else if (en_v) begin
        m_valid[idx] = 1; m_line[idx] = m_pc[31:2]; m_pending = 0;
        if (!stall_v) begin
          e_id_pc = m_pc; e_id_inst = fill; e_id_valid = 1; m_pc = m_pc + 4;
        end
      end else begin
        m_wait++;
        if (!stall_v) e_id_valid = 0;
      end
    end
    @(posedge clk);
    #1;
    checkOutput("id_valid", 32'(id_valid), 32'(e_id_valid));
    checkOutput("id_pc", id_pc, e_id_pc);
    checkOutput("id_inst", id_inst, e_id_inst);
  endtask

  // Cycle with the memory controller answering a pending fill after its latency
  task automatic autoCycle(input bit stall_v, input bit jmp_v, input logic [31:0] jaddr_v, input bit rdy_v);
    applyStimulus(1'b0, rdy_v, stall_v, jmp_v, jaddr_v, m_pending && (m_wait >= m_lat));
  endtask

  task automatic step(input bit en_v);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, en_v);
  endtask

  task automatic jump(input logic [31:0] a);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, a, 1'b0);
  endtask

  task automatic doReset();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; stall_in = 1'b0; jump_or_not = 1'b0;
    jump_addr = '0; mem_if_inst = '0; mem_if_enable = 1'b0;
    m_pc = 0; m_pending = 0; e_id_pc = 0; e_id_inst = 0; e_id_valid = 0;
    m_wait = 0; m_lat = 0;
    for (int i = 0; i < 128; i++) begin m_valid[i] = 0; m_line[i] = '0; end

    // Reset state
    doReset();
    checkOutput("rst_id_valid", 32'(id_valid), 32'h0);
    checkOutput("rst_id_pc", id_pc, 32'h0);
    checkOutput("rst_req", 32'(mem_if_request), 32'h0);
    checkOutput("rst_addr", mem_if_addr, 32'h0);

    // Cold start: miss at 0, fill 0x13, delivered one cycle after enable
    step(1'b0);
    checkOutput("t1_req", 32'(mem_if_request), 32'h1);
    checkOutput("t1_addr", mem_if_addr, 32'h0);
    step(1'b1);
    checkOutput("t1_valid", 32'(id_valid), 32'h1);
    checkOutput("t1_pc", id_pc, 32'h0);
    checkOutput("t1_inst", id_inst, 32'h00000013);
    step(1'b0);
    checkOutput("t1_next_req", 32'(mem_if_request), 32'h1);
    checkOutput("t1_next_addr", mem_if_addr, 32'h4);

    // Loop 0..0xC then jump back: second pass hits, one instruction per cycle
    for (int i = 0; i < 40 && !(m_pc == 32'h10 && !m_pending); i++) autoCycle(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("t2_last_pc", id_pc, 32'hC);
    jump(32'h0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0);
      checkOutput("t2_hit_pc", id_pc, 32'(i * 4));
      checkOutput("t2_hit_valid", 32'(id_valid), 32'h1);
      checkOutput("t2_no_req", 32'(mem_if_request), 32'h0);
    end

    // Stall holds a delivered pair and the pc; release moves to pc+4
    jump(32'h0);
    step(1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
      checkOutput("t4_hold_pc", id_pc, 32'h0);
      checkOutput("t4_hold_valid", 32'(id_valid), 32'h1);
      checkOutput("t4_hold_addr", mem_if_addr, 32'h4);
    end
    step(1'b0);
    checkOutput("t4_release_pc", id_pc, 32'h4);

    // Redirect mid-miss at 8: enable ignored, line 8 stays invalid
    doReset();
    jump(32'h8);
    step(1'b0);
    checkOutput("t3_req8", 32'(mem_if_request), 32'h1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 32'h100, 1'b1);
    checkOutput("t3_valid_drop", 32'(id_valid), 32'h0);
    step(1'b0);
    checkOutput("t3_req100", 32'(mem_if_request), 32'h1);
    checkOutput("t3_addr100", mem_if_addr, 32'h100);
    step(1'b1);
    jump(32'h8);
    step(1'b0);
    checkOutput("t3_line8_miss", 32'(mem_if_request), 32'h1);
    checkOutput("t3_line8_addr", mem_if_addr, 32'h8);
    step(1'b1);

    // Conflict: 0x000 and 0x200 share an index and evict each other
    doReset();
    step(1'b0);
    step(1'b1);
    jump(32'h200);
    step(1'b0);
    checkOutput("t5_req200", 32'(mem_if_request), 32'h1);
    step(1'b1);
    jump(32'h0);
    step(1'b0);
    checkOutput("t5_refetch_miss", 32'(mem_if_request), 32'h1);
    checkOutput("t5_refetch_addr", mem_if_addr, 32'h0);

    // rdy low during a miss freezes everything
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      checkOutput("t6_miss_req", 32'(mem_if_request), 32'h1);
      checkOutput("t6_miss_addr", mem_if_addr, 32'h0);
    end
    step(1'b1);
    checkOutput("t6_fill_pc", id_pc, 32'h0);
    // rdy low during a hit freezes everything
    jump(32'h0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      checkOutput("t6_hit_addr", mem_if_addr, 32'h0);
      checkOutput("t6_hit_valid", 32'(id_valid), 32'h0);
    end
    step(1'b0);
    checkOutput("t6_hit_resume", 32'(id_valid), 32'h1);
    // Reset mid-miss invalidates all lines
    step(1'b0);
    checkOutput("t6_pre_rst_req", 32'(mem_if_request), 32'h1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("t6_rst_req", 32'(mem_if_request), 32'h0);
    checkOutput("t6_rst_pc", mem_if_addr, 32'h0);
    step(1'b0);
    checkOutput("t6_rst_miss", 32'(mem_if_request), 32'h1);
    step(1'b1);

    // pc wraps past the top of the address space
    jump(32'hFFFFFFFC);
    step(1'b0);
    step(1'b1);
    checkOutput("wrap_pc", id_pc, 32'hFFFFFFFC);
    checkOutput("wrap_next", mem_if_addr, 32'h0);

    // Randomized traffic: stalls, redirects, rdy gaps, variable fill latency
    for (int i = 0; i < 400; i++) begin
      autoCycle(($urandom % 4) == 0, ($urandom % 10) == 0,
                (32'($urandom_range(0, 15)) << 2) | (($urandom % 2) != 0 ? 32'h200 : 32'h0),
                ($urandom % 8) != 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
